// File: rtl/fc_align_decoder.sv
// Fast-command word aligner/decoder: hunts the bit phase on repeated IDLE words,
// holds lock with a miss counter and decodes codes into one-hot strobes.
// Optional macro FC_HAMMING_TOLERANT_EN accepts words at Hamming distance 1 from a code.
module fc_align_decoder #(
  parameter int WORD_W = 8,
  parameter int NCMD = 10,
  parameter logic [NCMD*WORD_W-1:0] CMD_CODES = {8'hAA, 8'hA5, 8'h99, 8'h96, 8'h69,
                                                 8'h66, 8'h55, 8'h5A, 8'h33, 8'hF0},
  parameter int LOCK_CNT = 4,
  parameter int UNLOCK_CNT = 4,
  localparam int SW = $clog2(WORD_W)
) (
  input  logic              clk40,
  input  logic              rst,
  input  logic              selfAlignEn,
  input  logic [SW-1:0]     manualShift,
  input  logic [WORD_W-1:0] fcWord,
  output logic              aligned,
  output logic [SW-1:0]     bitShift,
  output logic [NCMD-1:0]   fcd,
  output logic              invalid,
  output logic [15:0]       errCnt
);

  localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] MISS_LAST = CW'(UNLOCK_CNT - 1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(WORD_W - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       miss_q;
  logic [SW-1:0]       shift_q;
  logic                aligned_q;
  logic [WORD_W-1:0]   prev_q;
  logic [NCMD-1:0]     fcd_q;
  logic                invalid_q;
  logic [15:0]         errcnt_q;

  logic [SW-1:0]       sel_s;
  logic [2*WORD_W-1:0] pair_s;
  logic [WORD_W-1:0]   win_s;
  logic                idle_s;
  logic [NCMD-1:0]     dec_s;
  logic                valid_s;
  logic [SW-1:0]       next_shift_s;

`ifdef FC_HAMMING_TOLERANT_EN
  function automatic logic dist1(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
    logic [WORD_W-1:0] x;
    x = a ^ b;
    return (x != {WORD_W{1'b0}}) &&
           ((x & (x - {{(WORD_W-1){1'b0}}, 1'b1})) == {WORD_W{1'b0}});
  endfunction
`endif

  assign sel_s        = selfAlignEn ? shift_q : manualShift;
  assign pair_s       = {prev_q, fcWord};
  assign win_s        = WORD_W'(pair_s >> sel_s);
  assign idle_s       = (win_s == CMD_CODES[WORD_W-1:0]);
  assign valid_s      = |dec_s;
  assign next_shift_s = (shift_q == SHIFT_LAST) ? {SW{1'b0}} : shift_q + SW'(1);

  // Lowest-index code lookup on the aligned window (exact hits take precedence)
  always_comb begin
    logic [NCMD-1:0] d;
    logic            found;
    d     = {NCMD{1'b0}};
    found = 1'b0;
    for (int i = 0; i < NCMD; i++) begin
      d[i]  = !found && (win_s == CMD_CODES[i*WORD_W +: WORD_W]);
      found = found | d[i];
    end
`ifdef FC_HAMMING_TOLERANT_EN
    for (int i = 0; i < NCMD; i++) begin
      d[i]  = d[i] | (!found && dist1(win_s, CMD_CODES[i*WORD_W +: WORD_W]));
      found = found | d[i];
    end
`endif
    dec_s = d;
  end

  // Alignment FSM: phase hunt, lock qualification and loss-of-lock tracking
  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      state_q   <= SEARCH;
      cnt_q     <= {CW{1'b0}};
      miss_q    <= {CW{1'b0}};
      shift_q   <= {SW{1'b0}};
      aligned_q <= 1'b0;
    end else if (!selfAlignEn) begin
      state_q   <= SEARCH;
      cnt_q     <= {CW{1'b0}};
      miss_q    <= {CW{1'b0}};
      shift_q   <= manualShift;
      aligned_q <= 1'b1;
    end else begin
      case (state_q)
        SEARCH: begin
          if (idle_s) begin
            if (LOCK_CNT == 1) begin
              state_q   <= LOCKED;
              aligned_q <= 1'b1;
            end else begin
              state_q   <= CHECK;
              cnt_q     <= CW'(1);
              aligned_q <= 1'b0;
            end
          end else begin
            shift_q   <= next_shift_s;
            aligned_q <= 1'b0;
          end
        end
        CHECK: begin
          if (idle_s && (cnt_q == LOCK_LAST)) begin
            state_q   <= LOCKED;
            cnt_q     <= {CW{1'b0}};
            aligned_q <= 1'b1;
          end else if (idle_s) begin
            cnt_q     <= cnt_q + CW'(1);
            aligned_q <= 1'b0;
          end else begin
            state_q   <= SEARCH;
            cnt_q     <= {CW{1'b0}};
            shift_q   <= next_shift_s;
            aligned_q <= 1'b0;
          end
        end
        LOCKED: begin
          if (valid_s) begin
            miss_q    <= {CW{1'b0}};
            aligned_q <= 1'b1;
          end else if (miss_q == MISS_LAST) begin
            state_q   <= SEARCH;
            miss_q    <= {CW{1'b0}};
            aligned_q <= 1'b0;
          end else begin
            miss_q    <= miss_q + CW'(1);
            aligned_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= SEARCH;
          cnt_q     <= {CW{1'b0}};
          miss_q    <= {CW{1'b0}};
          aligned_q <= 1'b0;
        end
      endcase
    end
  end

  // Word history, registered strobes and saturating error count
  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      prev_q    <= {WORD_W{1'b0}};
      fcd_q     <= {NCMD{1'b0}};
      invalid_q <= 1'b0;
      errcnt_q  <= 16'h0000;
    end else begin
      prev_q    <= fcWord;
      fcd_q     <= aligned_q ? dec_s : {NCMD{1'b0}};
      invalid_q <= aligned_q & ~valid_s;
      if (aligned_q && !valid_s && (errcnt_q != 16'hFFFF)) begin
        errcnt_q <= errcnt_q + 16'h0001;
      end else begin
        errcnt_q <= errcnt_q;
      end
    end
  end

  assign aligned  = aligned_q;
  assign bitShift = shift_q;
  assign fcd      = fcd_q;
  assign invalid  = invalid_q;
  assign errCnt   = errcnt_q;

endmodule

// File: tb/tb_fc_align_decoder.sv
// Self-checking bench for fc_align_decoder: serial command streams at chosen bit
// phases, compared every cycle against a behavioural model of the lock/decode rules.
module tb_fc_align_decoder;

  logic        clk40 = 1'b0;
  logic        rst;
  logic        selfAlignEn;
  logic [2:0]  manualShift;
  logic [7:0]  fcWord;
  logic        aligned;
  logic [2:0]  bitShift;
  logic [9:0]  fcd;
  logic        invalid;
  logic [15:0] errCnt;

  always #5 clk40 = ~clk40;

  fc_align_decoder dut (
    .clk40       (clk40),
    .rst         (rst),
    .selfAlignEn (selfAlignEn),
    .manualShift (manualShift),
    .fcWord      (fcWord),
    .aligned     (aligned),
    .bitShift    (bitShift),
    .fcd         (fcd),
    .invalid     (invalid),
    .errCnt      (errCnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] codes [10] = '{8'hF0, 8'h33, 8'h5A, 8'h55, 8'h66,
                             8'h69, 8'h96, 8'h99, 8'hA5, 8'hAA};

  // reference model state
  logic [7:0] m_prev;
  int         m_hunt;
  int         m_miss;
  int         m_shift;
  bit         m_locked;
  bit         m_aligned;
  logic [9:0] m_fcd;
  bit         m_inv;
  int         m_err;

  // serial stream generator: pend is the command whose bits complete next
  logic [7:0] pend;
  int         phase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [7:0] w);
    for (int i = 0; i < 10; i++) if (w == codes[i]) return i;
`ifdef FC_HAMMING_TOLERANT_EN
    for (int i = 0; i < 10; i++) if ($countones(w ^ codes[i]) == 1) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = 8'h00; m_hunt = 0; m_miss = 0; m_shift = 0;
    m_locked = 1'b0; m_aligned = 1'b0; m_fcd = 10'h000; m_inv = 1'b0; m_err = 0;
  endtask

  task automatic model_step(input logic [7:0] word);
    int s;
    int k;
    logic [15:0] pair;
    logic [7:0]  win;
    s    = selfAlignEn ? m_shift : int'(manualShift);
    pair = {m_prev, word};
    win  = 8'(pair >> s);
    k    = classify(win);
    if (m_aligned) begin
      m_fcd = (k >= 0) ? 10'(1 << k) : 10'h000;
      m_inv = (k < 0);
      if (m_inv && m_err < 65535) m_err++;
    end else begin
      m_fcd = 10'h000;
      m_inv = 1'b0;
    end
    if (!selfAlignEn) begin
      m_locked = 1'b0; m_hunt = 0; m_miss = 0; m_shift = int'(manualShift); m_aligned = 1'b1;
    end else if (!m_locked) begin
      // hunting: count consecutive IDLEs at this phase, else try the next phase
      if (win == codes[0]) begin
        m_hunt++;
        if (m_hunt >= 4) begin m_locked = 1'b1; m_hunt = 0; end
      end else begin
        m_hunt = 0;
        m_shift = (m_shift + 1) % 8;
      end
      m_aligned = m_locked;
    end else begin
      m_miss = (k >= 0) ? 0 : m_miss + 1;
      if (m_miss >= 4) begin m_locked = 1'b0; m_miss = 0; end
      m_aligned = m_locked;
    end
    m_prev = word;
  endtask

  task automatic check_all();
    chk("aligned", 32'(aligned), 32'(m_aligned));
    chk("bitShift", 32'(bitShift), 32'(m_shift));
    chk("fcd", 32'(fcd), 32'(m_fcd));
    chk("invalid", 32'(invalid), 32'(m_inv));
    chk("errCnt", 32'(errCnt), 32'(m_err));
  endtask

  task automatic step(input logic [7:0] word);
    fcWord = word;
    model_step(word);
    @(posedge clk40);
    #1;
    check_all();
  endtask

  task automatic push(input logic [7:0] cmd);
    logic [15:0] t;
    t = {pend, cmd};
    step(8'(t >> (8 - phase)));
    pend = cmd;
  endtask

  initial begin
    int e0;
    rst = 1'b1; selfAlignEn = 1'b1; manualShift = 3'd0; fcWord = 8'h00;
    model_reset();
    #2;
    check_all();
    @(negedge clk40);
    rst = 1'b0;

    // phase search on IDLE stream three bits off
    phase = 3; pend = 8'hF0;
    for (int i = 0; i < 6; i++) push(8'hF0);
    chk("t1_not_yet_aligned", 32'(aligned), 32'd0);
    push(8'hF0);
    chk("t1_aligned", 32'(aligned), 32'd1);
    chk("t1_shift", 32'(bitShift), 32'd3);

    // L1A decode
    push(8'h96);
    push(8'hF0);
    chk("t2_l1a_fcd", 32'(fcd), 32'h040);
    chk("t2_l1a_inv", 32'(invalid), 32'd0);
    push(8'hF0);
    chk("t2_l1a_once", 32'(fcd), 32'h001);

    // one-bit-corrupted L1A
    push(8'h97);
    push(8'hF0);
`ifdef FC_HAMMING_TOLERANT_EN
    e0 = 0;
    chk("t6_fcd", 32'(fcd), 32'h040);
    chk("t6_inv", 32'(invalid), 32'd0);
`else
    e0 = 1;
    chk("t6_fcd", 32'(fcd), 32'h000);
    chk("t6_inv", 32'(invalid), 32'd1);
`endif
    chk("t6_err", 32'(errCnt), 32'(e0));
    push(8'hF0);

    // three misses keep lock, four drop it
    push(8'h00); push(8'h00); push(8'h00); push(8'hF0);
    chk("t3_err3", 32'(errCnt), 32'(e0 + 3));
    chk("t3_keep", 32'(aligned), 32'd1);
    push(8'hF0);
    push(8'h00); push(8'h00); push(8'h00); push(8'h00); push(8'hF0);
    chk("t3_drop", 32'(aligned), 32'd0);
    chk("t3_err7", 32'(errCnt), 32'(e0 + 7));

    // manual phase, then hand over to self alignment
    selfAlignEn = 1'b0; manualShift = 3'd5; phase = 5;
    push(8'hF0); push(8'h69); push(8'hF0);
    chk("t4_manual_fcd", 32'(fcd), 32'h020);
    chk("t4_manual_aligned", 32'(aligned), 32'd1);
    chk("t4_manual_shift", 32'(bitShift), 32'd5);
    selfAlignEn = 1'b1;
    for (int i = 0; i < 4; i++) push(8'hF0);
    chk("t4_relock", 32'(aligned), 32'd1);
    chk("t4_relock_shift", 32'(bitShift), 32'd5);

    // asynchronous reset while locked
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_aligned", 32'(aligned), 32'd0);
    chk("t5_rst_shift", 32'(bitShift), 32'd0);
    chk("t5_rst_fcd", 32'(fcd), 32'd0);
    chk("t5_rst_inv", 32'(invalid), 32'd0);
    chk("t5_rst_err", 32'(errCnt), 32'd0);
    model_reset();
    @(negedge clk40);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) push(8'hF0);
    chk("t5_no_early_lock", 32'(aligned), 32'd0);
    push(8'hF0);
    chk("t5_relock", 32'(aligned), 32'd1);

    // random phases and random command/garbage streams
    for (int r = 0; r < 6; r++) begin
      phase = int'($urandom_range(0, 7));
      for (int i = 0; i < 14; i++) push(8'hF0);
      for (int i = 0; i < 25; i++) begin
        if ($urandom_range(0, 9) < 8) push(codes[$urandom_range(0, 9)]);
        else push(8'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_align_decoder.md
Name: fc_align_decoder

Overview:
Parametrised successor to the ETROC2 fast-command word-align/decoder. It accepts raw, unaligned WORD_W-bit deserialised fast-command words, one per clk40 cycle, and finds the bit phase autonomously by locking onto repeated IDLE words. It keeps lock with a miss counter and decodes NCMD commands from a parameter code table into one-cycle one-hot strobes. It sits between the fast-command deserialiser and the readout/trigger logic.

Parameters:
WORD_W, 8, fast-command word width in bits.
NCMD, 10, number of commands; index 0 is always IDLE.
CMD_CODES, {8'hAA,8'hA5,8'h99,8'h96,8'h69,8'h66,8'h55,8'h5A,8'h33,8'hF0}, packed NCMD*WORD_W codes; slice i = code of fcd[i] (0 IDLE, 1 LinkRst, 2 BCR, 3 SyncForTrig, 4 L1A_CR, 5 ChargeInj, 6 L1A, 7 L1A_BCR, 8 WSStart, 9 WSStop).
LOCK_CNT, 4, consecutive aligned IDLEs required to declare lock (>=1).
UNLOCK_CNT, 4, consecutive invalid words that drop lock (>=1).
SW, $clog2(WORD_W), shift field width (derived localparam).

Ports:
clk40  in  1  40 MHz word clock.
rst  in  1  Reset, asynchronous and active-high.
selfAlignEn  in  1  1: automatic alignment; 0: manual, uses manualShift.
manualShift  in  SW  Bit phase used when selfAlignEn=0.
fcWord  in  WORD_W  Raw word; a new word is presented every cycle.
aligned  out  1  1 while in LOCKED, or while selfAlignEn=0.
bitShift  out  SW  Current bit phase in use.
fcd  out  NCMD  Registered one-hot decoded command strobe.
invalid  out  1  One-cycle pulse: aligned word matched no code while aligned.
errCnt  out  16  Saturating count of invalid pulses.

Behaviour:
- Reset values: aligned=0, bitShift=0, fcd=0, invalid=0, errCnt=0, state=SEARCH, internal counters=0, prevWord=0.
- Window: prevWord registers fcWord each cycle. win = {prevWord,fcWord}[s+WORD_W-1 : s], with s = bitShift (or manualShift when selfAlignEn=0).
- Match: hit[i] = (win == CMD_CODES slice i). No match means invalid word.
- FSM (selfAlignEn=1):
  - SEARCH: if win==IDLE, go to CHECK with cnt=1. Otherwise bitShift increments; WORD_W-1 wraps to 0.
  - CHECK: if win==IDLE, cnt++; when cnt reaches LOCK_CNT, go to LOCKED. Any non-IDLE word returns to SEARCH with bitShift+1. If LOCK_CNT=1, a single IDLE in SEARCH goes directly to LOCKED.
  - LOCKED: miss counter clears on any valid word and increments on an invalid word. When it reaches UNLOCK_CNT, go to SEARCH with bitShift unchanged and aligned=0 from the next cycle.
- selfAlignEn=0: FSM is held in SEARCH with counters cleared. bitShift follows manualShift (registered). aligned=1 and decoding is active.
- selfAlignEn 0->1: FSM starts from SEARCH at the current bitShift.
- Decode: fcd[i]=1 for exactly one cycle, the cycle after the completing word is on fcWord. Latency is 1 clk40. Decoding happens only when aligned=1; otherwise fcd=0.
- At most one fcd bit is ever set. Duplicate codes in CMD_CODES resolve to the lowest index.
- invalid: asserted in the same cycle fcd would be, only when aligned=1. errCnt increments with invalid and holds at 16'hFFFF.
- fcd and invalid are never both 1.
- Async rst mid-operation forces all reset values immediately. Decoding resumes only after a fresh lock.

Optional Feature:
Macro FC_HAMMING_TOLERANT_EN.
- Defined: a win at Hamming distance exactly 1 from a code decodes as that code and does not count as invalid. Ties resolve to the lowest index. IDLE acceptance during SEARCH/CHECK still requires an exact match.
- Undefined: exact match only; every non-exact word is invalid.

Test Plan:
1. Stream of F0 rotated by 3 bits, selfAlignEn=1 -> bitShift walks 0..3. aligned rises after 4 consecutive IDLEs; no fcd before aligned.
2. Locked, inject 96 (L1A) -> fcd=10'h040 for exactly one cycle, 1 cycle later; invalid=0.
3. Locked, inject 3 consecutive 00 words then F0 -> invalid pulses 3 times, errCnt=3, lock kept. 4 consecutive 00 words -> aligned=0, state SEARCH.
4. selfAlignEn=0, manualShift=5, stream aligned at 5 -> aligned=1 immediately and commands decode. Switch to 1 -> relock at the same shift.
5. Locked, assert rst mid-stream -> all outputs 0 asynchronously; relock needs LOCK_CNT IDLEs.
6. With FC_HAMMING_TOLERANT_EN, inject 97 -> fcd[6] set, invalid=0. Without the macro -> invalid=1, errCnt+1.
